binary_counter_param_load: RTL and testbench
============================================

Name: binary_counter_param_load

Overview:
Parametrised up/down binary counter with parallel load, programmable terminal value and wrap or saturate mode. It generalises the fixed 4-bit loadable counter so that one module covers decade and mod-N counters, timers and cascaded wide counters. It sits in the datapath/timer library and cascades through cin/c_out.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VALUE, 2**WIDTH-1, terminal value; legal count range is 0..MAX_VALUE (must be <= 2**WIDTH-1).
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.

Ports:
clk  input  1  rising-edge clock.
clear  input  1  asynchronous active-high reset.
sclr  input  1  synchronous clear.
load  input  1  synchronous parallel load.
data_in  input  WIDTH  load value.
count  input  1  count enable.
up_dn  input  1  direction: 1 = up, 0 = down.
cin  input  1  cascade carry-in; tie high when unused.
count_out  output  WIDTH  registered counter value.
c_out  output  1  combinational cascade carry-out.
tc_pulse  output  1  registered one-cycle wrap indication.
sat_flag  output  1  registered sticky saturation flag.

Behaviour:
- Reset: clear=1 forces count_out=0, tc_pulse=0 and sat_flag=0 immediately, without waiting for clk. All later rules apply only while clear=0.
- Per-edge priority: sclr > load > step > hold.
- sclr=1: count_out<=0, tc_pulse<=0, sat_flag<=0.
- load=1 (sclr=0): count_out<=data_in. If data_in > MAX_VALUE, count_out<=MAX_VALUE (clamp). tc_pulse<=0, sat_flag<=0.
- step = count & cin & !load & !sclr.
- Step up, count_out < MAX_VALUE: count_out+1.
- Step up, count_out == MAX_VALUE: SATURATE=0 gives 0 with tc_pulse<=1. SATURATE=1 holds the value and sets sat_flag<=1.
- Step down, count_out > 0: count_out-1.
- Step down, count_out == 0: SATURATE=0 gives MAX_VALUE with tc_pulse<=1. SATURATE=1 holds the value and sets sat_flag<=1.
- tc_pulse goes high for exactly one cycle, on the edge after a wrap. On every other edge it goes to 0.
- sat_flag stays set until clear, sclr or load.
- Hold (no sclr, no load, no step): count_out unchanged, tc_pulse<=0, sat_flag unchanged.
- c_out = step & ((up_dn & count_out==MAX_VALUE) | (!up_dn & count_out==0)). It is purely combinational, asserted in both modes, and zero-latency so cascaded stages step on the same edge.
- Arithmetic is modulo 2**WIDTH internally. count_out never leaves 0..MAX_VALUE after reset.
- up_dn may change on any cycle; only the value sampled at the edge matters.
- clear asserted mid-count overrides everything asynchronously. Counting resumes on the first edge after clear deasserts.

Test Plan:
- WIDTH=4, MAX_VALUE=9, SATURATE=0, up: from 0, count=1, cin=1 for 10 edges -> sequence 1..9,0. tc_pulse=1 only in the cycle after 9->0. c_out=1 only while count_out=9.
- Same configuration, down from 0 -> next value 9 with tc_pulse=1. Then load=1, data_in=4'hF -> count_out=9 (clamped). Then load=1 together with count=1 -> load wins and c_out=0.
- SATURATE=1, MAX_VALUE=12: count up from 11 -> 12, then held at 12 with sat_flag=1 and no tc_pulse. Down 3 edges -> 9 with sat_flag still 1. sclr -> 0 and sat_flag=0.
- Cascade of two WIDTH=4 default instances (low c_out to high cin) counting up from 8'h0F -> 8'h10 on one edge. From 8'hFF -> 8'h00 with tc_pulse=1 on both stages.
- Assert clear asynchronously between edges at count_out=7 -> all outputs 0 before the next edge. Deassert -> counting resumes 1, 2, …. sclr and load on the same edge (data_in=5) -> 0.
- cin=0 with count=1 for 5 edges -> count_out held and c_out=0. Toggle up_dn every edge from 5 -> 6,5,6,5.

Source files
------------

// File: rtl/binary_counter_param_load.sv
// Parametrised up/down counter with parallel load, programmable terminal value
// and wrap/saturate behaviour; cascades through cin/c_out.
module binary_counter_param_load #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             count,
  input  logic             up_dn,
  input  logic             cin,
  output logic [WIDTH-1:0] count_out,
  output logic             c_out,
  output logic             tc_pulse,
  output logic             sat_flag
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic step;
  logic at_max;
  logic at_zero;
  logic at_bound;

  assign step     = count & cin & ~load & ~sclr;
  assign at_max   = (count_out == MAX_V);
  assign at_zero  = (count_out == '0);
  assign at_bound = up_dn ? at_max : at_zero;
  // Combinational so the next cascaded stage steps on the same edge.
  assign c_out    = step & at_bound;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_out <= '0;
      tc_pulse  <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (sclr) begin
      count_out <= '0;
      tc_pulse  <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (load) begin
      count_out <= (data_in > MAX_V) ? MAX_V : data_in;
      tc_pulse  <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (step) begin
      tc_pulse <= 1'b0;
      if (at_bound) begin
        if (SATURATE) begin
          sat_flag <= 1'b1;
        end else begin
          count_out <= up_dn ? '0 : MAX_V;
          tc_pulse  <= 1'b1;
        end
      end else begin
        count_out <= up_dn ? count_out + ONE : count_out - ONE;
      end
    end else begin
      tc_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_counter_param_load.sv
// Bench for binary_counter_param_load: mod-10 wrap, mod-13 saturate and an
// 8-bit cascade of two 4-bit stages, checked against an integer model.
module tb_binary_counter_param_load;

  logic       clk = 1'b0;
  logic       clear;
  logic       sclr, load, count, up_dn, cin;
  logic [7:0] data_in;

  logic [3:0] q[4];
  logic       co[4], tc[4], sf[4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: mod-10 wrap, 1: max 12 saturate, 2/3: cascade low/high (max 15 wrap)
  binary_counter_param_load #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_a (
    .clk(clk), .clear(clear), .sclr(sclr), .load(load), .data_in(data_in[3:0]),
    .count(count), .up_dn(up_dn), .cin(cin),
    .count_out(q[0]), .c_out(co[0]), .tc_pulse(tc[0]), .sat_flag(sf[0]));

  binary_counter_param_load #(.WIDTH(4), .MAX_VALUE(12), .SATURATE(1'b1)) u_b (
    .clk(clk), .clear(clear), .sclr(sclr), .load(load), .data_in(data_in[3:0]),
    .count(count), .up_dn(up_dn), .cin(cin),
    .count_out(q[1]), .c_out(co[1]), .tc_pulse(tc[1]), .sat_flag(sf[1]));

  binary_counter_param_load #(.WIDTH(4)) u_lo (
    .clk(clk), .clear(clear), .sclr(sclr), .load(load), .data_in(data_in[3:0]),
    .count(count), .up_dn(up_dn), .cin(cin),
    .count_out(q[2]), .c_out(co[2]), .tc_pulse(tc[2]), .sat_flag(sf[2]));

  binary_counter_param_load #(.WIDTH(4)) u_hi (
    .clk(clk), .clear(clear), .sclr(sclr), .load(load), .data_in(data_in[7:4]),
    .count(count), .up_dn(up_dn), .cin(co[2]),
    .count_out(q[3]), .c_out(co[3]), .tc_pulse(tc[3]), .sat_flag(sf[3]));

  // Integer model of each stage
  int m_val[4] = '{0, 0, 0, 0};
  bit m_tc[4]  = '{0, 0, 0, 0};
  bit m_sat[4] = '{0, 0, 0, 0};
  int max_of[4] = '{9, 12, 15, 15};
  bit sat_of[4] = '{0, 1, 0, 0};

  function automatic bit m_step(bit ci);
    return ci && count && !load && !sclr;
  endfunction

  function automatic bit m_cout(int i, bit ci);
    return m_step(ci) && (up_dn ? (m_val[i] == max_of[i]) : (m_val[i] == 0));
  endfunction

  function automatic bit m_cin(int i);
    return (i == 3) ? m_cout(2, cin) : cin;
  endfunction

  function automatic void m_next(int i, bit ci, int ld);
    int nv;
    m_tc[i] = 1'b0;
    if (sclr) begin
      m_val[i] = 0;
      m_sat[i] = 1'b0;
    end else if (load) begin
      m_val[i] = (ld > max_of[i]) ? max_of[i] : ld;
      m_sat[i] = 1'b0;
    end else if (ci && count) begin
      nv = up_dn ? m_val[i] + 1 : m_val[i] - 1;
      if (nv < 0 || nv > max_of[i]) begin
        if (sat_of[i]) m_sat[i] = 1'b1;
        else begin
          m_val[i] = (nv < 0) ? max_of[i] : 0;
          m_tc[i]  = 1'b1;
        end
      end else begin
        m_val[i] = nv;
      end
    end
  endfunction

  always begin
    @(posedge clk or posedge clear);
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = 0; m_tc[i] = 1'b0; m_sat[i] = 1'b0;
      end
    end else begin
      bit ci[4];
      for (int i = 0; i < 4; i++) ci[i] = m_cin(i);
      for (int i = 0; i < 4; i++)
        m_next(i, ci[i], (i == 3) ? int'(data_in[7:4]) : int'(data_in[3:0]));
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model count_out[%0d]", i), 32'(q[i]), 32'(m_val[i]));
      chk($sformatf("model tc_pulse[%0d]", i),  32'(tc[i]), 32'(m_tc[i]));
      chk($sformatf("model sat_flag[%0d]", i),  32'(sf[i]), 32'(m_sat[i]));
      chk($sformatf("model c_out[%0d]", i),     32'(co[i]), 32'(m_cout(i, m_cin(i))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_a[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    clear = 1'b1; sclr = 1'b0; load = 1'b0; count = 1'b0;
    up_dn = 1'b1; cin = 1'b1; data_in = 8'h00;
    tick(); tick();
    chk("reset count_a", 32'(q[0]), 0);
    chk("reset tc_a", 32'(tc[0]), 0);
    chk("reset sat_b", 32'(sf[1]), 0);
    clear = 1'b0;

    // mod-10 count up through the wrap
    count = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("up seq count_a", 32'(q[0]), 32'(seq_a[i]));
      chk("up seq tc_a", 32'(tc[0]), (i == 9) ? 1 : 0);
      chk("up seq c_out_a", 32'(co[0]), (i == 8) ? 1 : 0);
    end

    // down from 0 wraps to 9
    up_dn = 1'b0;
    tick();
    chk("down wrap count_a", 32'(q[0]), 9);
    chk("down wrap tc_a", 32'(tc[0]), 1);

    count = 1'b0; load = 1'b1; data_in = 8'hFF;
    tick();
    chk("load clamp count_a", 32'(q[0]), 9);
    chk("load clamp count_b", 32'(q[1]), 12);
    chk("load clamp tc_a", 32'(tc[0]), 0);

    // load beats step; c_out stays low even at the terminal value
    count = 1'b1; up_dn = 1'b1; data_in = 8'h03;
    #1 chk("load vs step c_out_a", 32'(co[0]), 0);
    tick();
    chk("load vs step count_a", 32'(q[0]), 3);

    // saturating instance
    count = 1'b0; data_in = 8'h0B;
    tick();
    load = 1'b0; count = 1'b1; up_dn = 1'b1;
    tick();
    chk("sat up count_b", 32'(q[1]), 12);
    chk("sat up flag_b", 32'(sf[1]), 0);
    tick();
    chk("sat hold count_b", 32'(q[1]), 12);
    chk("sat hold flag_b", 32'(sf[1]), 1);
    chk("sat hold tc_b", 32'(tc[1]), 0);
    up_dn = 1'b0;
    tick(); tick(); tick();
    chk("sat down count_b", 32'(q[1]), 9);
    chk("sat down flag_b", 32'(sf[1]), 1);
    count = 1'b0; sclr = 1'b1;
    tick();
    chk("sclr count_b", 32'(q[1]), 0);
    chk("sclr flag_b", 32'(sf[1]), 0);
    sclr = 1'b0;

    // 8-bit cascade
    load = 1'b1; data_in = 8'h0F;
    tick();
    load = 1'b0; count = 1'b1; up_dn = 1'b1;
    #1 chk("cascade c_out_lo", 32'(co[2]), 1);
    tick();
    chk("cascade 0F->10", 32'({q[3], q[2]}), 32'h10);
    count = 1'b0; load = 1'b1; data_in = 8'hFF;
    tick();
    load = 1'b0; count = 1'b1;
    tick();
    chk("cascade FF->00", 32'({q[3], q[2]}), 32'h00);
    chk("cascade tc_lo", 32'(tc[2]), 1);
    chk("cascade tc_hi", 32'(tc[3]), 1);

    // asynchronous clear mid-count
    count = 1'b0; sclr = 1'b1;
    tick();
    sclr = 1'b0; count = 1'b1; up_dn = 1'b1;
    repeat (7) tick();
    chk("pre-clear count_a", 32'(q[0]), 7);
    #2 clear = 1'b1;
    #1;
    chk("async clear count_a", 32'(q[0]), 0);
    chk("async clear count_b", 32'(q[1]), 0);
    chk("async clear tc_a", 32'(tc[0]), 0);
    tick();
    clear = 1'b0;
    tick();
    chk("resume 1 count_a", 32'(q[0]), 1);
    tick();
    chk("resume 2 count_a", 32'(q[0]), 2);

    sclr = 1'b1; load = 1'b1; data_in = 8'h05;
    tick();
    chk("sclr beats load count_a", 32'(q[0]), 0);
    sclr = 1'b0;
    tick();
    chk("load 5 count_a", 32'(q[0]), 5);

    // cin low blocks stepping
    load = 1'b0; cin = 1'b0; count = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cin low count_a", 32'(q[0]), 5);
      chk("cin low c_out_a", 32'(co[0]), 0);
    end

    // direction sampled per edge
    cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      chk("toggle dir count_a", 32'(q[0]), (i % 2 == 0) ? 6 : 5);
    end

    count = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
